// File: rtl/matrix_pkg.sv
// Shared constants and types for the 2x2 matrix operand path.
package matrix_pkg;
   localparam int unsigned ELEM_W  = 4;
   localparam int unsigned N_ELEMS = 8;
   localparam int unsigned CNT_W   = $clog2(N_ELEMS);

   // Row-major element positions, A before B
   localparam int unsigned IDX_A00 = 0;
   localparam int unsigned IDX_A01 = 1;
   localparam int unsigned IDX_A10 = 2;
   localparam int unsigned IDX_A11 = 3;
   localparam int unsigned IDX_B00 = 4;
   localparam int unsigned IDX_B01 = 5;
   localparam int unsigned IDX_B10 = 6;
   localparam int unsigned IDX_B11 = 7;

   typedef enum logic {LOAD, PRESENT} ld_state_e;
endpackage

// File: rtl/matrix_elem_bank.sv
// 8-entry element register file: indexed single-element write, whole-bank load, flat read.
module matrix_elem_bank
   import matrix_pkg::*;
#(
   parameter int unsigned DW = ELEM_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [CNT_W-1:0]        widx,
   input  logic [DW-1:0]           wdata,
   input  logic                    ld,
   input  logic [N_ELEMS*DW-1:0]   ldata,
   output logic [N_ELEMS*DW-1:0]   rdata
);
   logic [N_ELEMS-1:0][DW-1:0] mem;

   // Whole-bank load takes priority over a single-element write
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else if (ld) begin
         mem <= ldata;
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem;
endmodule

// File: rtl/matrix_operand_loader.sv
// Collects a row-major A/B element stream and presents it as a registered 2x2 operand set.
// Define MATRIX_OPERAND_LOADER_DBUF_EN to add a load bank so loading overlaps presentation.
module matrix_operand_loader
   import matrix_pkg::*;
#(
   parameter int unsigned DW = ELEM_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_sof,
   output logic          in_ready,
   output logic [DW-1:0] A00,
   output logic [DW-1:0] A01,
   output logic [DW-1:0] A10,
   output logic [DW-1:0] A11,
   output logic [DW-1:0] B00,
   output logic [DW-1:0] B01,
   output logic [DW-1:0] B10,
   output logic [DW-1:0] B11,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          frame_err
);
   localparam int unsigned BUS_W = N_ELEMS * DW;

   ld_state_e        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, widx;
   logic             we, done, err_n;
   logic [BUS_W-1:0] ops;

   // Classify an accepted beat against the frame counter
   always_comb begin
      cnt_n = cnt;
      widx  = cnt;
      we    = 1'b0;
      done  = 1'b0;
      err_n = 1'b0;
      if (in_valid && in_ready) begin
         if (in_sof) begin
            we    = 1'b1;
            widx  = CNT_W'(IDX_A00);
            cnt_n = CNT_W'(1);
            err_n = (cnt != '0);
         end else if (cnt == '0) begin
            err_n = 1'b1;
         end else begin
            we    = 1'b1;
            cnt_n = CNT_W'(cnt + 1'b1);
            done  = (cnt == CNT_W'(IDX_B11));
         end
      end
   end

`ifdef MATRIX_OPERAND_LOADER_DBUF_EN
   logic             lfull, lfull_n, xfer;
   logic [BUS_W-1:0] lbank;

   // Present-bank FSM; a full load bank moves over when the output side frees up
   always_comb begin
      state_n = state;
      lfull_n = lfull;
      xfer    = lfull && ((state == LOAD) || out_ready);
      case (state)
         LOAD:    if (xfer) state_n = PRESENT;
         PRESENT: if (out_ready && !lfull) state_n = LOAD;
         default: state_n = LOAD;
      endcase
      if (xfer) lfull_n = 1'b0;
      if (done) lfull_n = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) lfull <= 1'b0;
      else     lfull <= lfull_n;
   end

   assign in_ready = !(lfull && (state == PRESENT));

   matrix_elem_bank #(.DW(DW)) u_load_bank (
      .clk(clk), .rst(rst), .we(we), .widx(widx), .wdata(in_data),
      .ld(1'b0), .ldata('0), .rdata(lbank)
   );

   matrix_elem_bank #(.DW(DW)) u_pres_bank (
      .clk(clk), .rst(rst), .we(1'b0), .widx('0), .wdata('0),
      .ld(xfer), .ldata(lbank), .rdata(ops)
   );
`else
   // Single bank: load fills the outputs in place, then holds them until taken
   always_comb begin
      state_n = state;
      case (state)
         LOAD:    if (done) state_n = PRESENT;
         PRESENT: if (out_ready) state_n = LOAD;
         default: state_n = LOAD;
      endcase
   end

   assign in_ready = (state == LOAD);

   matrix_elem_bank #(.DW(DW)) u_bank (
      .clk(clk), .rst(rst), .we(we), .widx(widx), .wdata(in_data),
      .ld(1'b0), .ldata('0), .rdata(ops)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         cnt       <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         frame_err <= err_n;
      end
   end

   assign out_valid = (state == PRESENT);

   assign A00 = ops[IDX_A00*DW +: DW];
   assign A01 = ops[IDX_A01*DW +: DW];
   assign A10 = ops[IDX_A10*DW +: DW];
   assign A11 = ops[IDX_A11*DW +: DW];
   assign B00 = ops[IDX_B00*DW +: DW];
   assign B01 = ops[IDX_B01*DW +: DW];
   assign B10 = ops[IDX_B10*DW +: DW];
   assign B11 = ops[IDX_B11*DW +: DW];
endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the 2×2 combinational matrix multiplier.
- Accepts matrix elements one at a time on a 4-bit valid/ready stream, in row-major order: A00, A01, A10, A11, B00, B01, B10, B11.
- Once all 8 elements are collected, presents them in parallel as a registered, stable operand set with a valid/ready handshake.
- Detects frame misalignment using a start-of-frame marker.

Parameters:
- DW, 4, element width in bits; matches the multiplier's operand width.

Ports:
- clk  input  1  single system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  DW  matrix element
- in_valid  input  1  in_data is valid
- in_sof  input  1  marks the A00 beat of a frame; qualified by in_valid
- in_ready  output  1  loader can accept a beat
- A00, A01, A10, A11  output  DW each  matrix A operands, registered
- B00, B01, B10, B11  output  DW each  matrix B operands, registered
- out_valid  output  1  operand set is complete and stable
- out_ready  input  1  consumer takes the operand set
- frame_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Beat accepted: in_valid & in_ready on a rising edge.
- Element counter cnt runs 0..7; element index = cnt, row-major, A before B.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - PRESENT: in_ready=0, out_valid=1.
- Reset values: state LOAD, cnt=0, all A*/B* outputs 0, out_valid 0, frame_err 0. in_ready=1 while in LOAD, including during rst; beats presented during rst are ignored.
- LOAD, accepted beat:
  - cnt==0 and in_sof=1: store at index 0, cnt←1.
  - cnt==0 and in_sof=0: beat dropped, frame_err pulses, cnt stays 0.
  - cnt!=0 and in_sof=1: partial frame discarded, frame_err pulses, beat stored at index 0, cnt←1.
  - cnt!=0 and in_sof=0: store at index cnt, cnt←cnt+1.
  - cnt==7 (no sof): store B11, cnt←0, state←PRESENT.
- Latency: out_valid rises the cycle after the 8th beat is accepted.
- PRESENT: all 8 outputs held constant. in_valid, in_sof and in_data are ignored; no error is flagged.
- out_valid & out_ready: next cycle out_valid=0 and state=LOAD. The earliest next beat is accepted that same next cycle.
- Outputs are written in place during LOAD. Values are meaningful only while out_valid=1; partially loaded values may be visible while out_valid=0.
- No arithmetic in this block. Elements pass through unmodified at full width DW.
- Reset mid-operation: any partial frame or presented set is discarded; state, cnt and outputs return to reset values on the next edge.

Optional Feature:
- Macro: MATRIX_OPERAND_LOADER_DBUF_EN.
- With the macro: adds a separate 8-element load bank.
  - Loading continues while PRESENT. in_ready=0 only when the load bank is complete and the present bank is still occupied.
  - A complete load bank transfers to the outputs on the cycle after out_valid & out_ready; out_valid stays high through the transfer.
  - Alternatively, it transfers one cycle after completion if the output bank is empty.
  - Sustained throughput: one operand set per 8 cycles with out_ready tied high.
- Without the macro: single bank, behaviour exactly as above; throughput is one set per 9 cycles.

Decomposition:
- Shared package matrix_pkg holds:
  - ELEM_W=4
  - N_ELEMS=8
  - index constants IDX_A00..IDX_B11 (0..7)
  - loader state enum {LOAD, PRESENT}
- One natural sub-module: matrix_elem_bank, an 8×DW register file with indexed write enable and a flat parallel read. It is instantiated once normally and twice under DBUF_EN.

Test Plan:
- Stream 1,2,3,4,5,6,7,8 with in_sof on the first beat, out_ready=1:
  - A00..A11=1,2,3,4 and B00..B11=5,6,7,8.
  - out_valid high exactly 1 cycle, starting the cycle after beat 8.
  - Attached multiplier gives C00=19, C01=22, C10=43, C11=50.
- Same frame with out_ready=0 for 10 cycles while in_valid=1:
  - Outputs unchanged and in_ready=0 throughout; no beats are consumed.
  - After out_ready=1, the next frame loads correctly.
- 3 beats, then a beat 9 with in_sof=1, then 7 more beats:
  - frame_err=1 for one cycle on the sof beat.
  - Presented A00=9 plus the 7 following values.
- First beat 0xF with in_sof=0:
  - Beat dropped, frame_err pulses, cnt stays 0.
  - A subsequent proper frame presents correctly.
- rst pulsed for 1 cycle after 5 beats:
  - All outputs 0 and out_valid 0.
  - A fresh 8-beat frame of all 0xF presents all elements = 15.
- With MATRIX_OPERAND_LOADER_DBUF_EN, 4 back-to-back frames, in_valid=1 and out_ready=1 continuously:
  - 4 out_valid handshakes in 32+2 cycles.
  - in_ready never drops.
